module_leaky_relu_lut_loader: RTL

MODULE_LEAKY_RELU_LUT_LOADER -- requirements
Module: module_leaky_relu_lut_loader

---
 rtl/module_leaky_relu_lut_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/module_leaky_relu_lut_loader.sv
// rtl/module_leaky_relu_lut_loader.sv - streams packed 32-bit words into a byte-wide LUT bank, one entry per cycle
module module_leaky_relu_lut_loader #(
  parameter int DEPTH    = 256,
  parameter int ADDR_BIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                s_valid,
  input  logic [31:0]         s_data,
  output logic                s_ready,
  output logic                we_a,
  output logic [ADDR_BIT-1:0] addr_a,
  output logic [7:0]          di_a,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int                  WCNT_W       = ADDR_BIT - 1;
  localparam logic [WCNT_W-1:0]   WORDS_TOTAL  = WCNT_W'(DEPTH / 4);
  localparam logic [ADDR_BIT:0]   WRITES_TOTAL = (ADDR_BIT + 1)'(DEPTH);

  logic [1:0]          state_q, state_d;
  logic [23:0]         buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic [ADDR_BIT:0]   wr_cnt_q, wr_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic [7:0]          di_q, di_d;

  logic                accept;
  logic [7:0]          next_byte;

  // byte_idx_q names the byte currently on di_a; byte 0 never needs buffering
  always_comb begin
    case (byte_idx_q)
      2'd0:    next_byte = buf_q[7:0];
      2'd1:    next_byte = buf_q[15:8];
      default: next_byte = buf_q[23:16];
    endcase
  end

  assign s_ready = (state_q == LOAD) && (!buf_valid_q || (byte_idx_q == 2'd3)) &&
                   (words_q < WORDS_TOTAL);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    byte_idx_d  = byte_idx_q;
    words_d     = words_q;
    wr_cnt_d    = wr_cnt_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    di_d        = di_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          buf_d       = '0;
          buf_valid_d = 1'b0;
          byte_idx_d  = 2'd0;
          words_d     = '0;
          wr_cnt_d    = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d     = IDLE;
          buf_valid_d = 1'b0;
          byte_idx_d  = 2'd0;
        end else if (we_q && (wr_cnt_q == WRITES_TOTAL)) begin
          // final entry is on the bus this cycle; done follows it
          state_d     = DONE;
          buf_valid_d = 1'b0;
        end else if (accept) begin
          buf_d       = s_data[31:8];
          buf_valid_d = 1'b1;
          byte_idx_d  = 2'd0;
          words_d     = words_q + WCNT_W'(1);
          we_d        = 1'b1;
          addr_d      = wr_cnt_q[ADDR_BIT-1:0];
          di_d        = s_data[7:0];
          wr_cnt_d    = wr_cnt_q + (ADDR_BIT + 1)'(1);
        end else if (buf_valid_q && (byte_idx_q != 2'd3)) begin
          byte_idx_d  = byte_idx_q + 2'd1;
          we_d        = 1'b1;
          addr_d      = wr_cnt_q[ADDR_BIT-1:0];
          di_d        = next_byte;
          wr_cnt_d    = wr_cnt_q + (ADDR_BIT + 1)'(1);
        end else begin
          buf_valid_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      byte_idx_q  <= 2'd0;
      words_q     <= '0;
      wr_cnt_q    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      di_q        <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      byte_idx_q  <= byte_idx_d;
      words_q     <= words_d;
      wr_cnt_q    <= wr_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
    end
  end

  assign we_a   = we_q;
  assign addr_a = addr_q;
  assign di_a   = di_q;
  assign busy   = (state_q == LOAD);
  assign done   = (state_q == DONE);

endmodule
